// File: rtl/tproc_pkg.sv
// Shared definitions for the tile processor datapath: store FSM states,
// default tile geometry and lane packing of a buffer word.
package tproc_pkg;

    typedef enum logic [1:0] {
        STORE_IDLE  = 2'd0,
        STORE_READ  = 2'd1,
        STORE_DRAIN = 2'd2,
        STORE_DONE  = 2'd3
    } store_state_e;

    localparam int COL_MAX_DEF = 4;
    localparam int ROW_MAX_DEF = 3;
    localparam int LANE_W      = 16;
    localparam int LANES       = 8;

endpackage

// File: rtl/o_feature_store_if.sv
// External write port of the feature store: valid/ready word writes with
// address. The store engine is the master, the memory side is the slave.
interface o_feature_store_if
    import tproc_pkg::*;
#(
    parameter int DATA_W = LANES * LANE_W
);
    logic              ext_wr_en;
    logic [15:0]       ext_wr_addr;
    logic [DATA_W-1:0] ext_wr_data;
    logic              ext_wr_ready;

    modport master (
        output ext_wr_en,
        output ext_wr_addr,
        output ext_wr_data,
        input  ext_wr_ready
    );

    modport slave (
        input  ext_wr_en,
        input  ext_wr_addr,
        input  ext_wr_data,
        output ext_wr_ready
    );
endinterface

// File: rtl/o_feature_store_skid.sv
// Two-entry fall-through FIFO between buffer read data and the external write
// port; an empty FIFO passes its input straight to the output in the same cycle.
module store_skid_buf #(
    parameter int W = 144
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occ
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;
    logic         empty;

    assign empty     = (occ == 2'd0);
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : mem[rd_ptr];
    assign pop       = out_ready && !empty;
    // A word that arrives into an empty FIFO and is accepted at once never lands in storage.
    assign push      = in_valid && !(empty && out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end
endmodule

// File: rtl/o_feature_store.sv
// Writeback engine draining the output feature buffer to external memory with
// tile addressing and bank toggling. Optional lane ReLU: O_FEATURE_STORE_RELU_EN.
module o_feature_store
    import tproc_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int COL_MAX = COL_MAX_DEF,
    parameter int ROW_MAX = ROW_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              store_enable,
    input  logic [7:0]        src_addr,
    input  logic [15:0]       dst_addr,
    input  logic [7:0]        mem_sel,
    input  logic [7:0]        store_counter,
    output logic              buf_rd_en,
    output logic [14:0]       buf_rd_addr,
    output logic              buf_sel,
    input  logic [DATA_W-1:0] buf_rd_data,
    o_feature_store_if.master wr,
    output logic              store_busy,
    output logic              store_done
);
    localparam logic [3:0] COL_LAST = 4'(COL_MAX);
    localparam logic [3:0] ROW_LAST = 4'(ROW_MAX);
    localparam int         SKID_W   = 16 + DATA_W;

    store_state_e      state;
    store_state_e      state_nxt;
    logic [7:0]        rd_addr_p0;
    logic [7:0]        rd_cnt;
    logic [7:0]        wr_cnt;
    logic [7:0]        n_words;
    logic              rd_issue;
    logic              credit_ok;
    logic              start;
    logic              xfer;
    logic              vld_p1;
    logic [15:0]       wa_p1;
    logic [DATA_W-1:0] data_p1;
    logic              skid_vld;
    logic [SKID_W-1:0] skid_out;
    logic [1:0]        skid_occ;
    logic              unused_mem_sel;

    assign unused_mem_sel = ^mem_sel[7:1];

    function automatic logic [7:0] next_tile_addr(input logic [7:0] a);
        logic [3:0] col;
        logic [3:0] row;
        col = a[3:0];
        row = a[7:4];
        if (col == COL_LAST) begin
            col = 4'd0;
            row = (row == ROW_LAST) ? 4'd0 : row + 4'd1;
        end else begin
            col = col + 4'd1;
        end
        return {row, col};
    endfunction

    function automatic logic tile_wraps(input logic [7:0] a);
        return (a[3:0] == COL_LAST) && (a[7:4] == ROW_LAST);
    endfunction

`ifdef O_FEATURE_STORE_RELU_EN
    function automatic logic [DATA_W-1:0] relu_lanes(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0]        r;
        logic signed [LANE_W-1:0] lane;
        r = d;
        for (int i = 0; i < DATA_W / LANE_W; i++) begin
            lane = d[i*LANE_W +: LANE_W];
            r[i*LANE_W +: LANE_W] = (lane < 0) ? '0 : lane;
        end
        return r;
    endfunction

    assign data_p1 = relu_lanes(buf_rd_data);
`else
    assign data_p1 = buf_rd_data;
`endif

    assign start     = (state == STORE_IDLE) && store_enable;
    assign n_words   = (store_counter == 8'd0) ? 8'd1 : store_counter;
    assign xfer      = wr.ext_wr_en && wr.ext_wr_ready;
    // Reads in flight plus parked words may never exceed the two skid slots.
    assign credit_ok = ({1'b0, skid_occ} + {2'b00, vld_p1}) < 3'd2;

    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        case (state)
            STORE_IDLE: begin
                if (store_enable) begin
                    state_nxt = STORE_READ;
                end
            end
            STORE_READ: begin
                rd_issue = credit_ok && (rd_cnt != 8'd0);
                if (rd_issue && (rd_cnt == 8'd1)) begin
                    state_nxt = STORE_DRAIN;
                end
            end
            STORE_DRAIN: begin
                if ((wr_cnt == 8'd0) || ((wr_cnt == 8'd1) && xfer)) begin
                    state_nxt = STORE_DONE;
                end
            end
            STORE_DONE: begin
                state_nxt = STORE_IDLE;
            end
            default: begin
                state_nxt = STORE_IDLE;
            end
        endcase
    end

    // p0: read issue and tile address walk
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STORE_IDLE;
            rd_addr_p0 <= 8'd0;
            buf_sel    <= 1'b0;
            rd_cnt     <= 8'd0;
            wr_cnt     <= 8'd0;
            vld_p1     <= 1'b0;
            wa_p1      <= 16'd0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= rd_issue;
            if (start) begin
                rd_addr_p0 <= src_addr;
                buf_sel    <= mem_sel[0];
                rd_cnt     <= n_words;
                wr_cnt     <= n_words;
                wa_p1      <= dst_addr;
            end else begin
                if (rd_issue) begin
                    rd_cnt     <= rd_cnt - 8'd1;
                    rd_addr_p0 <= next_tile_addr(rd_addr_p0);
                    if (tile_wraps(rd_addr_p0)) begin
                        buf_sel <= ~buf_sel;
                    end
                end
                if (xfer) begin
                    wr_cnt <= wr_cnt - 8'd1;
                end
                if (vld_p1) begin
                    wa_p1 <= wa_p1 + 16'd1;
                end
            end
        end
    end

    // p1: returned buffer word paired with its external address
    store_skid_buf #(
        .W (SKID_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld_p1),
        .in_data   ({wa_p1, data_p1}),
        .out_valid (skid_vld),
        .out_data  (skid_out),
        .out_ready (wr.ext_wr_ready),
        .occ       (skid_occ)
    );

    assign buf_rd_en      = rd_issue;
    assign buf_rd_addr    = {7'd0, rd_addr_p0};
    assign wr.ext_wr_en   = skid_vld;
    assign wr.ext_wr_addr = skid_vld ? skid_out[SKID_W-1 -: 16] : 16'd0;
    assign wr.ext_wr_data = skid_vld ? skid_out[DATA_W-1:0] : '0;
    assign store_busy     = (state == STORE_READ) || (state == STORE_DRAIN);
    assign store_done     = (state == STORE_DONE);
endmodule
